alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Request/response sequencer for an external LEGv8-style ALU: decodes the opcode,
// drives registered operands, captures the ALU result and counts completions.
module alu_sequencer #(
  parameter int n          = 64,
  parameter int countWidth = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [10:0]           Opcode,
  input  logic [n-1:0]          OpA,
  input  logic [n-1:0]          OpB,
  output logic [n-1:0]          BusA,
  output logic [n-1:0]          BusB,
  output logic [3:0]            ALUCtrl,
  input  logic [n-1:0]          BusW,
  input  logic                  Zero,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [n-1:0]          Result,
  output logic                  ZeroOut,
  output logic                  BranchTaken,
  output logic                  IllegalOp,
  output logic [countWidth-1:0] OpCount
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

  localparam logic [3:0] ctrlAnd   = 4'b0000;
  localparam logic [3:0] ctrlOr    = 4'b0001;
  localparam logic [3:0] ctrlAdd   = 4'b0010;
  localparam logic [3:0] ctrlSub   = 4'b0110;
  localparam logic [3:0] ctrlPassB = 4'b0111;

  stateT state, nextState;

  logic [3:0] decodedCtrl;
  logic       decodedIllegal;
  logic       decodedCbz;
  logic       decodedCbnz;

  logic illegalReg;
  logic isCbz;
  logic isCbnz;

  logic accept;
  logic capture;
  logic retire;

  assign accept  = (state == IDLE) && ReqValid;
  assign capture = (state == EXEC);
  assign retire  = (state == RESP) && RspReady;

  assign ReqReady = (state == IDLE);
  assign RspValid = (state == RESP);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    decodedCtrl    = ctrlPassB;
    decodedIllegal = 1'b0;
    decodedCbz     = 1'b0;
    decodedCbnz    = 1'b0;
    casez (Opcode)
      11'b10001011000: decodedCtrl = ctrlAdd;   // ADD
      11'b11001011000: decodedCtrl = ctrlSub;   // SUB
      11'b10001010000: decodedCtrl = ctrlAnd;   // AND
      11'b10101010000: decodedCtrl = ctrlOr;    // ORR
      11'b11111000010: decodedCtrl = ctrlAdd;   // LDUR
      11'b11111000000: decodedCtrl = ctrlAdd;   // STUR
      11'b10110100???: decodedCbz  = 1'b1;
      11'b10110101???: decodedCbnz = 1'b1;
      default:         decodedIllegal = 1'b1;
    endcase
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (ReqValid) nextState = EXEC;
      EXEC:    nextState = RESP;
      RESP:    if (RspReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // Operand bus and decoded control only move on the accept edge.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      BusA       <= '0;
      BusB       <= '0;
      ALUCtrl    <= ctrlAnd;
      illegalReg <= 1'b0;
      isCbz      <= 1'b0;
      isCbnz     <= 1'b0;
    end else if (accept) begin
      BusA       <= OpA;
      BusB       <= OpB;
      ALUCtrl    <= decodedCtrl;
      illegalReg <= decodedIllegal;
      isCbz      <= decodedCbz;
      isCbnz     <= decodedCbnz;
    end
  end

  // Response fields are captured once, on the EXEC->RESP edge, and held until the next capture.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      Result      <= '0;
      ZeroOut     <= 1'b0;
      BranchTaken <= 1'b0;
      IllegalOp   <= 1'b0;
    end else if (capture) begin
      Result      <= illegalReg ? '0 : BusW;
      ZeroOut     <= illegalReg ? 1'b1 : Zero;
      BranchTaken <= (isCbz & Zero) | (isCbnz & ~Zero);
      IllegalOp   <= illegalReg;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      OpCount <= '0;
    end else if (retire && (OpCount != {countWidth{1'b1}})) begin
      OpCount <= OpCount + countWidth'(1);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized bench for alu_sequencer with a behavioural ALU and an
// opcode-level reference model; a narrow-counter instance exercises saturation.
module tb_alu_sequencer;

  localparam int n = 64;

  localparam logic [10:0] opAdd  = 11'b10001011000;
  localparam logic [10:0] opSub  = 11'b11001011000;
  localparam logic [10:0] opAnd  = 11'b10001010000;
  localparam logic [10:0] opOrr  = 11'b10101010000;
  localparam logic [10:0] opLdur = 11'b11111000010;
  localparam logic [10:0] opStur = 11'b11111000000;
  localparam logic [10:0] opCbz  = 11'b10110100000;
  localparam logic [10:0] opCbnz = 11'b10110101000;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          ReqValid;
  logic          ReqReady;
  logic [10:0]   Opcode;
  logic [n-1:0]  OpA, OpB, BusA, BusB, BusW, Result;
  logic [3:0]    ALUCtrl;
  logic          Zero, RspValid, RspReady, ZeroOut, BranchTaken, IllegalOp;
  logic [15:0]   OpCount;

  logic          sReqValid, sReqReady, sRspValid, sRspReady, sZero;
  logic          sZeroOut, sBranchTaken, sIllegalOp;
  logic [10:0]   sOpcode;
  logic [7:0]    sOpA, sOpB, sBusA, sBusB, sBusW, sResult;
  logic [3:0]    sALUCtrl;
  logic [3:0]    sOpCount;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] expCount;
  logic [63:0] prevResult;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [63:0] result;
    logic        zero;
    logic        branch;
    logic        illegal;
  } expT;

  alu_sequencer #(.n(n)) dut (
    .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .Opcode(Opcode), .OpA(OpA), .OpB(OpB), .BusA(BusA), .BusB(BusB),
    .ALUCtrl(ALUCtrl), .BusW(BusW), .Zero(Zero), .RspValid(RspValid),
    .RspReady(RspReady), .Result(Result), .ZeroOut(ZeroOut),
    .BranchTaken(BranchTaken), .IllegalOp(IllegalOp), .OpCount(OpCount)
  );

  alu_sequencer #(.n(8), .countWidth(4)) dutSmall (
    .CLK(CLK), .Reset(Reset), .ReqValid(sReqValid), .ReqReady(sReqReady),
    .Opcode(sOpcode), .OpA(sOpA), .OpB(sOpB), .BusA(sBusA), .BusB(sBusB),
    .ALUCtrl(sALUCtrl), .BusW(sBusW), .Zero(sZero), .RspValid(sRspValid),
    .RspReady(sRspReady), .Result(sResult), .ZeroOut(sZeroOut),
    .BranchTaken(sBranchTaken), .IllegalOp(sIllegalOp), .OpCount(sOpCount)
  );

  always #5 CLK = ~CLK;

  // External ALU behaviour.
  always_comb begin
    BusW = '0;
    case (ALUCtrl)
      4'b0000: BusW = BusA & BusB;
      4'b0001: BusW = BusA | BusB;
      4'b0010: BusW = BusA + BusB;
      4'b0110: BusW = BusA - BusB;
      4'b0111: BusW = BusB;
      default: BusW = '0;
    endcase
  end
  assign Zero   = (BusW == '0);
  assign sBusW  = sBusA + sBusB;
  assign sZero  = (sBusW == '0);

  // What an instruction should produce, straight from its meaning.
  function automatic expT refModel(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
    expT e;
    e.illegal = 1'b0;
    e.branch  = 1'b0;
    if (op == opAdd || op == opLdur || op == opStur) begin
      e.ctrl = 4'd2; e.result = a + b;
    end else if (op == opSub) begin
      e.ctrl = 4'd6; e.result = a - b;
    end else if (op == opAnd) begin
      e.ctrl = 4'd0; e.result = a & b;
    end else if (op == opOrr) begin
      e.ctrl = 4'd1; e.result = a | b;
    end else if (op[10:3] == opCbz[10:3]) begin
      e.ctrl = 4'd7; e.result = b; e.branch = (b == 64'd0);
    end else if (op[10:3] == opCbnz[10:3]) begin
      e.ctrl = 4'd7; e.result = b; e.branch = (b != 64'd0);
    end else begin
      e.ctrl = 4'd7; e.result = 64'd0; e.illegal = 1'b1;
    end
    e.zero = e.illegal ? 1'b1 : (e.result == 64'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkResp(input string tag, input expT e, input logic [63:0] a, input logic [63:0] b);
    check({tag, " RspValid"},    {63'd0, RspValid},    64'd1);
    check({tag, " ReqReady"},    {63'd0, ReqReady},    64'd0);
    check({tag, " Result"},      Result,               e.result);
    check({tag, " ZeroOut"},     {63'd0, ZeroOut},     {63'd0, e.zero});
    check({tag, " BranchTaken"}, {63'd0, BranchTaken}, {63'd0, e.branch});
    check({tag, " IllegalOp"},   {63'd0, IllegalOp},   {63'd0, e.illegal});
    check({tag, " BusA"},        BusA,                 a);
    check({tag, " BusB"},        BusB,                 b);
    check({tag, " ALUCtrl"},     {60'd0, ALUCtrl},     {60'd0, e.ctrl});
    check({tag, " OpCount"},     {48'd0, OpCount},     {48'd0, expCount});
  endtask

  // One full transaction; stall = RESP cycles with RspReady low, holdReq keeps ReqValid up with junk.
  task automatic doOp(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                      input int stall, input bit holdReq);
    expT e;
    e = refModel(op, a, b);
    check("idle ReqReady", {63'd0, ReqReady}, 64'd1);
    ReqValid = 1'b1; Opcode = op; OpA = a; OpB = b;
    RspReady = 1'b1;
    @(posedge CLK); #1;
    check("accept ALUCtrl",  {60'd0, ALUCtrl},  {60'd0, e.ctrl});
    check("accept BusA",     BusA,              a);
    check("accept BusB",     BusB,              b);
    check("exec RspValid",   {63'd0, RspValid}, 64'd0);
    check("exec ReqReady",   {63'd0, ReqReady}, 64'd0);
    check("exec Result hold", Result,           prevResult);
    if (holdReq) begin
      OpA = ~a; OpB = ~b; Opcode = opSub;
    end else begin
      ReqValid = 1'b0;
    end
    @(posedge CLK); #1;
    checkResp("resp", e, a, b);
    RspReady = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK); #1;
      checkResp("stall", e, a, b);
    end
    RspReady = 1'b1;
    @(posedge CLK); #1;
    if (expCount != 16'hFFFF) expCount = expCount + 16'd1;
    check("done OpCount",  {48'd0, OpCount},  {48'd0, expCount});
    check("done RspValid", {63'd0, RspValid}, 64'd0);
    check("done ReqReady", {63'd0, ReqReady}, 64'd1);
    check("done Result",   Result,            e.result);
    ReqValid = 1'b0;
    RspReady = 1'b0;
    prevResult = e.result;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, " RspValid"},    {63'd0, RspValid},    64'd0);
    check({tag, " ReqReady"},    {63'd0, ReqReady},    64'd1);
    check({tag, " BusA"},        BusA,                 64'd0);
    check({tag, " BusB"},        BusB,                 64'd0);
    check({tag, " ALUCtrl"},     {60'd0, ALUCtrl},     64'd0);
    check({tag, " Result"},      Result,               64'd0);
    check({tag, " ZeroOut"},     {63'd0, ZeroOut},     64'd0);
    check({tag, " BranchTaken"}, {63'd0, BranchTaken}, 64'd0);
    check({tag, " IllegalOp"},   {63'd0, IllegalOp},   64'd0);
    check({tag, " OpCount"},     {48'd0, OpCount},     64'd0);
  endtask

  logic [10:0] opTable [8];
  logic [10:0] op;
  logic [63:0] a, b;

  initial begin
    opTable[0] = opAdd;  opTable[1] = opSub;  opTable[2] = opAnd; opTable[3] = opOrr;
    opTable[4] = opLdur; opTable[5] = opStur; opTable[6] = opCbz; opTable[7] = opCbnz;

    Reset = 1'b1; ReqValid = 1'b1; RspReady = 1'b1; Opcode = opAdd; OpA = 64'd9; OpB = 64'd9;
    sReqValid = 1'b0; sRspReady = 1'b0; sOpcode = opAdd; sOpA = 8'd1; sOpB = 8'd2;
    expCount = 16'd0; prevResult = 64'd0;
    repeat (2) @(posedge CLK);
    #1;
    checkResetState("reset");
    Reset = 1'b0; ReqValid = 1'b0; RspReady = 1'b0;

    // Reset during EXEC aborts the request without a response.
    ReqValid = 1'b1; Opcode = opAdd; OpA = 64'd3; OpB = 64'd4;
    @(posedge CLK); #1;
    check("abort accepted BusA", BusA, 64'd3);
    Reset = 1'b1; RspReady = 1'b1;
    @(posedge CLK); #1;
    checkResetState("abort exec");
    Reset = 1'b0; ReqValid = 1'b0; RspReady = 1'b0;
    @(posedge CLK); #1;
    check("abort no response", {63'd0, RspValid}, 64'd0);

    // Directed cases.
    doOp(opAdd, 64'd5, 64'd7, 0, 1'b0);
    check("add 5+7", Result, 64'd12);
    doOp(opSub, 64'h1234, 64'h1234, 1, 1'b0);
    check("sub zero", {63'd0, ZeroOut}, 64'd1);
    doOp(opCbz, 64'd77, 64'd0, 0, 1'b0);
    check("cbz taken", {63'd0, BranchTaken}, 64'd1);
    doOp(opCbnz | 11'd5, 64'd77, 64'd0, 0, 1'b0);
    check("cbnz not taken", {63'd0, BranchTaken}, 64'd0);
    doOp(11'b00000000000, 64'hDEAD, 64'hBEEF, 2, 1'b0);
    check("illegal flag", {63'd0, IllegalOp}, 64'd1);
    doOp(opOrr, 64'hF0F0, 64'h0F0F, 4, 1'b1);
    doOp(opAnd, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1'b1);
    doOp(opAdd, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = int'($urandom_range(0, 8));
      if (sel == 8) op = 11'($urandom);
      else          op = opTable[sel] | ((sel >= 6) ? 11'($urandom_range(0, 7)) : 11'd0);
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = 64'd0;
        1:       b = a;
        default: b = {$urandom, $urandom};
      endcase
      doOp(op, a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset during RESP also drops the response.
    ReqValid = 1'b1; Opcode = opAdd; OpA = 64'd1; OpB = 64'd1;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    @(posedge CLK); #1;
    check("pre-abort RspValid", {63'd0, RspValid}, 64'd1);
    Reset = 1'b1; RspReady = 1'b1; ReqValid = 1'b1;
    @(posedge CLK); #1;
    checkResetState("abort resp");
    Reset = 1'b0; RspReady = 1'b0; ReqValid = 1'b0;
    expCount = 16'd0; prevResult = 64'd0;
    doOp(opStur, 64'd100, 64'd28, 0, 1'b0);

    // Back-to-back traffic on a 4-bit counter: saturates at 0xF instead of wrapping.
    sReqValid = 1'b1; sRspReady = 1'b1;
    repeat (42) @(posedge CLK);
    #1;
    check("small count 14", {60'd0, sOpCount}, 64'd14);
    repeat (3) @(posedge CLK);
    #1;
    check("small count 15", {60'd0, sOpCount}, 64'd15);
    repeat (6) @(posedge CLK);
    #1;
    check("small count saturated", {60'd0, sOpCount}, 64'd15);
    sReqValid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
